// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared constants and FSM state type for the sequential multiplier
package seq_mult_pkg;

  localparam int SEQ_OP_W     = 4;
  localparam int SEQ_PROD_W   = 2 * SEQ_OP_W;
  localparam int SEQ_ITER_CNT = SEQ_OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - control FSM and iteration counter for seq_mult_core
// Emits load/step/finish strobes to the datapath; latency is fixed at ITER_CNT steps.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int ITER_CNT = SEQ_ITER_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_load,
  output logic o_step,
  output logic o_finish,
  output logic o_busy,
  output logic o_done
);

  localparam int CNT_W = (ITER_CNT > 1) ? $clog2(ITER_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_load) begin
        r_cnt <= '0;
      end else if (o_step) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_load      = 1'b0;
    o_step      = 1'b0;
    o_finish    = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          o_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        o_step = 1'b1;
        // the last iteration's add is folded into the product load
        if (r_cnt == LAST_CNT) begin
          o_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/seq_mult_core.sv
// rtl/seq_mult_core.sv - shift-add sequential multiplier, sign-magnitude datapath
// Build option SEQ_MULT_SIGNED_EN: defined = two's-complement operands, undefined = unsigned.
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int OP_W   = SEQ_OP_W,
  parameter int PROD_W = 2 * OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam logic [OP_W:0]     MAG_ONE  = (OP_W + 1)'(1);
  localparam logic [PROD_W-1:0] PROD_ONE = PROD_W'(1);

  logic w_load;
  logic w_step;
  logic w_finish;
  logic w_busy;
  logic w_done;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [OP_W:0]     w_a_ext;
  logic [OP_W:0]     w_b_ext;
  logic [OP_W:0]     w_a_mag;
  logic [OP_W:0]     w_b_mag;
  logic [PROD_W-1:0] w_addend;
  logic [PROD_W-1:0] w_acc_nxt;
  logic [PROD_W-1:0] w_prod_nxt;

  logic [PROD_W-1:0] r_mcand;
  logic [OP_W:0]     r_mplr;
  logic [PROD_W-1:0] r_acc;
  logic              r_sign;
  logic [PROD_W-1:0] r_product;

  seq_mult_ctrl #(
    .ITER_CNT (OP_W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (start),
    .o_load   (w_load),
    .o_step   (w_step),
    .o_finish (w_finish),
    .o_busy   (w_busy),
    .o_done   (w_done)
  );

`ifdef SEQ_MULT_SIGNED_EN
  assign w_a_neg = a[OP_W-1];
  assign w_b_neg = b[OP_W-1];
`else
  assign w_a_neg = 1'b0;
  assign w_b_neg = 1'b0;
`endif

  // one extra bit so that the most negative operand has a representable magnitude
  assign w_a_ext = {w_a_neg, a};
  assign w_b_ext = {w_b_neg, b};
  assign w_a_mag = w_a_neg ? (~w_a_ext + MAG_ONE) : w_a_ext;
  assign w_b_mag = w_b_neg ? (~w_b_ext + MAG_ONE) : w_b_ext;

  assign w_addend   = r_mplr[0] ? r_mcand : '0;
  assign w_acc_nxt  = r_acc + w_addend;
  // negating zero yields zero, so no negative-zero case exists
  assign w_prod_nxt = r_sign ? (~w_acc_nxt + PROD_ONE) : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_sign    <= 1'b0;
      r_product <= '0;
    end else begin
      if (w_load) begin
        r_mcand <= PROD_W'(w_a_mag);
        r_mplr  <= w_b_mag;
        r_acc   <= '0;
        r_sign  <= w_a_neg ^ w_b_neg;
      end else if (w_step) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
      end
      if (w_finish) begin
        r_product <= w_prod_nxt;
      end
    end
  end

  assign busy    = w_busy;
  assign done    = w_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_core.sv
// tb/tb_seq_mult_core.sv - self-checking bench for seq_mult_core
// Reference model follows SEQ_MULT_SIGNED_EN the same way the design does.
module tb_seq_mult_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mult_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
    int sx;
    int sy;
    int p;
`ifdef SEQ_MULT_SIGNED_EN
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
`else
    sx = int'(x);
    sy = int'(y);
`endif
    p = sx * sy;
    return p[7:0];
  endfunction

  // one operation; start and operands are scrambled while busy, a=7/b=7 with start always at i==2
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] exp,
                       input string tag);
    logic [7:0] prev;
    logic [7:0] prod_at_done;
    int         done_cnt;
    int         done_idx;
    int         busy_cnt;
    bit         stable;
    prev = product;
    prod_at_done = 8'hxx;
    done_cnt = 0;
    done_idx = 0;
    busy_cnt = 0;
    stable = 1'b1;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = i;
        prod_at_done = product;
      end
      if (i <= 4 && product !== prev) stable = 1'b0;
      if (i <= 5) begin
        start = (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        a = (i == 2) ? 4'd7 : 4'($urandom);
        b = (i == 2) ? 4'd7 : 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_edge"}, 32'(done_idx - 1), 32'd4);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, "_calc_stable"}, 32'(stable), 32'd1);
    check({tag, "_prod_at_done"}, 32'(prod_at_done), 32'(exp));
    check({tag, "_prod_held"}, 32'(product), 32'(exp));
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    int         d_cnt;
    int         d_first;
    int         d_second;
    logic [7:0] exp_hold;

    rst_n = 1'b0;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(4'd3, 4'd5, 8'h0F, "mul_3x5");
`ifdef SEQ_MULT_SIGNED_EN
    do_op(4'h8, 4'h8, 8'h40, "mul_m8xm8");
    do_op(4'h9, 4'd6, 8'hD6, "mul_m7x6");
    do_op(4'h8, 4'd7, 8'hC8, "mul_m8x7");
    do_op(4'hF, 4'hF, 8'h01, "mul_FxF");
`else
    do_op(4'h8, 4'h8, 8'h40, "mul_8x8");
    do_op(4'h9, 4'd6, 8'h36, "mul_9x6");
    do_op(4'h8, 4'd7, 8'h38, "mul_8x7");
    do_op(4'hF, 4'hF, 8'hE1, "mul_FxF");
`endif
    do_op(4'd0, 4'hB, 8'h00, "mul_0xm5");
    do_op(4'd3, 4'd5, 8'h0F, "mul_3x5_again");

    // reset in the second CALC cycle
    @(negedge clk);
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) d_cnt++;
    end
    check("abort_no_done", 32'(d_cnt), 32'd0);
    do_op(4'd2, 4'd7, model(4'd2, 4'd7), "post_reset");

    // start held high: back-to-back operations
    @(negedge clk);
    a = 4'd5;
    b = 4'hD;
    start = 1'b1;
    exp_hold = model(4'd5, 4'hD);
    d_cnt = 0;
    d_first = 0;
    d_second = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        d_cnt++;
        if (d_first == 0) d_first = i;
        else d_second = i;
      end
      if (i >= 7) start = 1'b0;
    end
    check("held_done_cnt", 32'(d_cnt), 32'd2);
    check("held_first", 32'(d_first), 32'd5);
    check("held_gap", 32'(d_second - d_first), 32'd6);
    check("held_product", 32'(product), 32'(exp_hold));

    for (int n = 0; n < 10; n++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      do_op(ra, rb, model(ra, rb), $sformatf("rand%0d_%h_%h", n, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_core.md
SEQ_MULT_CORE -- requirements
Module: seq_mult_core

Interface
REQ-001 Parameter OP_W, default 4: operand width in bits.
REQ-002 Parameter PROD_W, default 8: product width, fixed at 2*OP_W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  OP_W  multiplicand, two's complement by default.
REQ-007 b  input  OP_W  multiplier, two's complement by default.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking a new valid product.
REQ-010 product  output  PROD_W  result in two's complement; drives the anode display decoders.

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE.
REQ-012 IDLE with start=1 at edge k SHALL capture |a|, |b| and sign=a[MSB]^b[MSB], clear the accumulator and iteration counter, and go to CALC.
REQ-013 CALC SHALL perform one shift-add iteration per cycle: if multiplier LSB=1, add the shifted multiplicand to the accumulator; then shift the multiplicand left and the multiplier right.
REQ-014 The counter SHALL count 0..OP_W-1; the edge where it equals OP_W-1 (edge k+OP_W) SHALL load product and go to DONE.
REQ-015 The loaded product SHALL be the accumulator, or its two's-complement negation when sign=1.
REQ-016 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-017 Latency SHALL be fixed: done is high in the cycle after edge k+OP_W, independent of the operand values.
REQ-018 product SHALL hold its value from the DONE cycle until the next product load; it SHALL NOT change during CALC.
REQ-019 start in CALC or DONE SHALL be ignored, and operand changes during CALC SHALL have no effect.
REQ-020 If start is held high, a new operation SHALL be accepted on the first IDLE cycle after DONE.
REQ-021 A zero result with sign=1 SHALL produce 0, never a negative zero.
REQ-022 Operand -2^(OP_W-1) SHALL use magnitude 2^(OP_W-1) held in OP_W+1 bits: -8*-8=64 and -8*7=-56 are exact.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, product=0 and clear all internal registers.
REQ-024 Reset during CALC or DONE SHALL abort the operation and produce no done pulse.
REQ-025 After rst_n rises, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-026 Macro SEQ_MULT_SIGNED_EN defined: operands are two's complement, and sign handling follows REQ-012, REQ-015, REQ-021 and REQ-022.
REQ-027 Macro SEQ_MULT_SIGNED_EN undefined: operands are unsigned, sign is forced to 0, and product is unsigned (maximum 15*15=225).
REQ-028 Latency and handshake SHALL be identical in both builds.

Structure
REQ-029 Package seq_mult_pkg SHALL hold OP_W and PROD_W defaults, the iteration-count constant and the state enum (IDLE, CALC, DONE).
REQ-030 The FSM and iteration counter SHALL sit in sub-module seq_mult_ctrl, which outputs load, step, finish and busy.
REQ-031 The datapath (magnitude registers, accumulator, sign register, product register) SHALL stay in seq_mult_core.

Verification
REQ-032 a=3, b=5, pulse start -> done exactly 4 cycles after the accepting edge, product=8'h0F, busy high for 5 cycles.
REQ-033 a=-8, b=-8 -> product=8'h40 (64); a=-7, b=6 -> product=8'hD6 (-42).
REQ-034 a=0, b=-5 -> product=8'h00, with no negative-zero artefact.
REQ-035 Start at 3*5, then assert start with a=7, b=7 during CALC -> ignored, product=8'h0F, single done pulse.
REQ-036 Reset asserted in the 2nd CALC cycle -> outputs zero at once, no done pulse; a new start afterwards completes normally.
REQ-037 SEQ_MULT_SIGNED_EN undefined, a=4'hF, b=4'hF -> product=8'hE1 (225) with the same 4-cycle latency.
